// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared constants and pointer helpers for the async FIFO
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int ADDR_W_DEFAULT = 4;

  // Operates on a 32-bit container so both pointer blocks can share it at any
  // width; callers zero-extend the binary pointer and keep the low bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_sync_2ff.sv
// ============================================================================
// fifo_sync_2ff : two-flop synchronizer, async active-low reset to zero
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module fifo_sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_q = r_q2;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_ptr_full.sv
// ============================================================================
// fifo_wr_ptr_full : write-domain pointer, Gray publish and full flag
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module fifo_wr_ptr_full
  import fifo_pkg::*;
#(
  parameter int number_of_bit_address = ADDR_W_DEFAULT
) (
  input  logic                             wclk,
  input  logic                             RST_WR,
  input  logic                             winc,
  input  logic [number_of_bit_address:0]   rptr_gray_async,
  output logic [number_of_bit_address-1:0] waddr,
  output logic                             wclken,
  output logic                             wfull,
  output logic [number_of_bit_address:0]   wptr_gray
);

  localparam int A = number_of_bit_address;

  logic [A:0]  r_wbin;
  logic [A:0]  r_wptr_gray;
  logic        r_wfull;

  logic [A:0]  w_rq2;
  logic [A:0]  w_bin_next;
  logic [31:0] w_gray_wide;
  logic [A:0]  w_gray_next;
  logic [A:0]  w_full_cmp;
  logic        w_full_next;
  logic        w_unused_gray;

  fifo_sync_2ff #(
    .WIDTH (A + 1)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (RST_WR),
    .i_d   (rptr_gray_async),
    .o_q   (w_rq2)
  );

  assign wclken      = winc & ~r_wfull;
  assign w_bin_next  = r_wbin + {{A{1'b0}}, wclken};
  assign w_gray_wide = bin2gray(32'(w_bin_next));
  assign w_gray_next = w_gray_wide[A:0];
  assign w_unused_gray = ^w_gray_wide[31:A+1];

  // Full when the next write pointer is exactly one lap ahead of the read
  // pointer: in Gray code that means the top two bits differ, the rest match.
  assign w_full_cmp  = {~w_rq2[A:A-1], w_rq2[A-2:0]};
  assign w_full_next = (w_gray_next == w_full_cmp);

  always_ff @(posedge wclk or negedge RST_WR) begin
    if (!RST_WR) begin
      r_wbin      <= '0;
      r_wptr_gray <= '0;
      r_wfull     <= 1'b0;
    end else begin
      r_wbin      <= w_bin_next;
      r_wptr_gray <= w_gray_next;
      r_wfull     <= w_full_next;
    end
  end

  assign waddr     = r_wbin[A-1:0];
  assign wptr_gray = r_wptr_gray;
  assign wfull     = r_wfull;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_ptr_full.sv
// ============================================================================
// tb_fifo_wr_ptr_full : scenario and randomized checks against an occupancy model
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_ptr_full;

  localparam int A = 4;

  logic         wclk = 1'b0;
  logic         RST_WR;
  logic         winc;
  logic [A:0]   rptr_gray_async;
  logic [A-1:0] waddr;
  logic         wclken;
  logic         wfull;
  logic [A:0]   wptr_gray;

  int n_pass  = 0;
  int n_total = 0;

  // Model: write count and read count mod 32; the flag sees the read count
  // as it was two edges earlier.
  int m_wcnt, m_rd, m_s1, m_s2;
  bit m_full;

  fifo_wr_ptr_full #(.number_of_bit_address(A)) dut (
    .wclk            (wclk),
    .RST_WR          (RST_WR),
    .winc            (winc),
    .rptr_gray_async (rptr_gray_async),
    .waddr           (waddr),
    .wclken          (wclken),
    .wfull           (wfull),
    .wptr_gray       (wptr_gray)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_full = 1'b0;
  endtask

  task automatic drive(input logic w, input int rd);
    @(negedge wclk);
    winc = w;
    m_rd = rd % 32;
    rptr_gray_async = to_gray(m_rd);
    #1;
  endtask

  task automatic tick();
    int acc, wn;
    @(posedge wclk);
    acc    = (winc && !m_full) ? 1 : 0;
    wn     = (m_wcnt + acc) % 32;
    m_full = (((wn - m_s2 + 32) % 32) == 16);
    m_s2   = m_s1;
    m_s1   = m_rd;
    m_wcnt = wn;
    #1;
  endtask

  task automatic do_reset();
    @(negedge wclk);
    RST_WR = 1'b0; winc = 1'b0; rptr_gray_async = '0;
    model_reset();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    RST_WR = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge wclk);
    RST_WR = 1'b0; winc = 1'b1; rptr_gray_async = '0;
    model_reset();
    @(posedge wclk); #1;
    n_total++; if (waddr !== 4'd0) $display("FAIL reset_waddr: got %0d expected 0", waddr); else n_pass++;
    n_total++; if (wptr_gray !== 5'd0) $display("FAIL reset_gray: got %b expected 00000", wptr_gray); else n_pass++;
    n_total++; if (wfull !== 1'b0) $display("FAIL reset_full: got %b expected 0", wfull); else n_pass++;
    n_total++; if (wclken !== 1'b1) $display("FAIL reset_wclken_follows: got %b expected 1", wclken); else n_pass++;
    winc = 1'b0; #1;
    n_total++; if (wclken !== 1'b0) $display("FAIL reset_wclken_low: got %b expected 0", wclken); else n_pass++;
    @(negedge wclk);
    RST_WR = 1'b1;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 0);
      n_total++; if (waddr !== 4'(i) || wclken !== 1'b1 || wfull !== 1'b0)
        $display("FAIL fill_step%0d: got waddr=%0d wclken=%b wfull=%b expected waddr=%0d wclken=1 wfull=0", i, waddr, wclken, wfull, i);
      else n_pass++;
      tick();
    end
    n_total++; if (wfull !== 1'b1 || m_full !== 1'b1) $display("FAIL fill_full: got %b model %b expected 1", wfull, m_full); else n_pass++;
    n_total++; if (wptr_gray !== 5'b11000) $display("FAIL fill_gray: got %b expected 11000", wptr_gray); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0);
      n_total++; if (wclken !== 1'b0) $display("FAIL ovf_wclken%0d: got %b expected 0", i, wclken); else n_pass++;
      tick();
      n_total++; if (waddr !== 4'd0 || wptr_gray !== 5'b11000 || wfull !== 1'b1)
        $display("FAIL ovf_hold%0d: got waddr=%0d gray=%b full=%b expected 0 11000 1", i, waddr, wptr_gray, wfull);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    // winc stays high: blocked while full, flag clears on the third edge.
    for (int e = 1; e <= 3; e++) begin
      drive(1'b1, 1);
      n_total++; if (wclken !== 1'b0) $display("FAIL rel_blocked%0d: got wclken=%b expected 0", e, wclken); else n_pass++;
      tick();
      n_total++; if (wfull !== (e < 3) || wfull !== m_full)
        $display("FAIL rel_full_edge%0d: got %b expected %b", e, wfull, (e < 3));
      else n_pass++;
    end
    n_total++; if (wclken !== 1'b1 || waddr !== 4'd0) $display("FAIL rel_next_write: got wclken=%b waddr=%0d expected 1 0", wclken, waddr); else n_pass++;
    drive(1'b1, 1);
    tick();
    n_total++; if (wfull !== 1'b1 || waddr !== 4'd1 || wptr_gray !== 5'b11001)
      $display("FAIL rel_last_slot: got full=%b waddr=%0d gray=%b expected 1 1 11001", wfull, waddr, wptr_gray);
    else n_pass++;
  endtask

  task automatic test_gray();
    logic [4:0] prev;
    do_reset();
    prev = wptr_gray;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 0);
      tick();
      n_total++; if ($countones(prev ^ wptr_gray) != 1)
        $display("FAIL gray_onebit%0d: got %b from %b expected one bit change", i, wptr_gray, prev);
      else n_pass++;
      prev = wptr_gray;
    end
    n_total++; if (wptr_gray !== 5'b00111) $display("FAIL gray_five: got %b expected 00111", wptr_gray); else n_pass++;
  endtask

  task automatic test_wrap();
    int rd;
    int bad;
    do_reset();
    rd  = 0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, rd);
      tick();
      if (wfull !== 1'b0) bad++;
      rd = m_wcnt;
      drive(1'b0, rd);
      tick();
      if (wfull !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL wrap_spurious_full: got %0d full cycles expected 0", bad); else n_pass++;
    n_total++; if (waddr !== 4'd0 || wptr_gray !== 5'd0 || m_wcnt != 0)
      $display("FAIL wrap_return: got waddr=%0d gray=%b expected 0 00000", waddr, wptr_gray);
    else n_pass++;
  endtask

  task automatic test_random();
    int rd;
    logic w;
    do_reset();
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 3) != 0);
      if (((m_wcnt - rd + 32) % 32) > 0 && $urandom_range(0, 2) == 0) rd = (rd + 1) % 32;
      drive(w, rd);
      n_total++; if (wclken !== (w && !m_full)) $display("FAIL rnd_wclken%0d: got %b expected %b", i, wclken, (w && !m_full)); else n_pass++;
      tick();
      n_total++; if (waddr !== 4'(m_wcnt % 16) || wptr_gray !== to_gray(m_wcnt) || wfull !== m_full)
        $display("FAIL rnd_state%0d: got waddr=%0d gray=%b full=%b expected %0d %b %b", i, waddr, wptr_gray, wfull, m_wcnt % 16, to_gray(m_wcnt), m_full);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 0);
      tick();
    end
    n_total++; if (waddr !== 4'd7 || wptr_gray !== 5'b00100) $display("FAIL arst_pre: got waddr=%0d gray=%b expected 7 00100", waddr, wptr_gray); else n_pass++;
    @(negedge wclk);
    #2 RST_WR = 1'b0;
    #1;
    n_total++; if (waddr !== 4'd0 || wptr_gray !== 5'd0 || wfull !== 1'b0)
      $display("FAIL arst_immediate: got waddr=%0d gray=%b full=%b expected 0 00000 0", waddr, wptr_gray, wfull);
    else n_pass++;
    winc = 1'b0;
    model_reset();
    @(negedge wclk);
    RST_WR = 1'b1;
  endtask

  initial begin
    RST_WR = 1'b0;
    winc = 1'b0;
    rptr_gray_async = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_gray();
    test_wrap();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
